// File: rtl/rx_buf_reader_pkg.sv
// Shared types, header field offsets and helpers for the rx buffer reader.
package rx_buf_reader_pkg;

   localparam int unsigned DATA_W  = 64;
   localparam int unsigned STRB_W  = 8;
   localparam int unsigned USER_W  = 32;
   localparam int unsigned LEN_W   = 16;
   localparam int unsigned WCNT_W  = 14;
   localparam int unsigned DES_LSB = 56;
   localparam int unsigned SRC_LSB = 48;
   localparam int unsigned LEN_LSB = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HDR    = 2'd1,
      DATA   = 2'd2,
      COMMIT = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic [USER_W-1:0] user;
      logic              last;
   } beat_t;

   // Byte enables for the final beat of a frame of the given length.
   function automatic logic [STRB_W-1:0] strb_from_len(input logic [LEN_W-1:0] len);
      logic [STRB_W-1:0] s;
      if (len[2:0] == 3'd0) s = 8'hFF;
      else                  s = 8'((9'd1 << len[2:0]) - 9'd1);
      return s;
   endfunction

endpackage

// File: rtl/rx_buf_reader_skid.sv
// Two-entry skid buffer between the buffer read pipeline and the AXI-Stream port.
module rx_skid_buf
   import rx_buf_reader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  beat_t      in_beat,
   output logic       out_valid,
   input  logic       out_ready,
   output beat_t      out_beat,
   output logic [1:0] level
);

   beat_t      mem [2];
   logic       wr_idx;
   logic       rd_idx;
   logic [1:0] cnt;
   logic       push;
   logic       pop;

   assign in_ready  = (cnt != 2'd2);
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_beat  = mem[rd_idx];
   assign level     = cnt;

   // Entries only change on push, so the head is stable while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= in_beat;
            wr_idx      <= ~wr_idx;
         end
         if (pop) rd_idx <= ~rd_idx;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/rx_buf_reader.sv
// Reads committed frames (header + data words) from the rx buffer and streams them out.
// Optional statistics counters are enabled with RX_BUF_READER_STATS_EN.
module rx_buf_reader
   import rx_buf_reader_pkg::*;
#(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] commited_wr_address,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [63:0]       rd_data,
   output logic [63:0]       m_axis_tdata,
   output logic [7:0]        m_axis_tstrb,
   output logic [31:0]       m_axis_tuser,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [ADDR_W-1:0] commited_rd_address,
   output logic              rd_addr_updated
`ifdef RX_BUF_READER_STATS_EN
   ,
   output logic [31:0]       rx_frames,
   output logic [47:0]       rx_bytes
`endif
);

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   p_q;
   logic [ADDR_W-1:0]   cw_q;
   logic [ADDR_W-1:0]   rd_ptr_q;
   logic [ADDR_W-1:0]   crd_q;
   logic                upd_q;
   logic [USER_W-1:0]   hdr_q;
   logic [WCNT_W-1:0]   w_q;
   logic [WCNT_W-1:0]   iss_cnt_q;
   logic [WCNT_W-1:0]   psh_cnt_q;
   logic                infl_q;

   logic                avail;
   logic [LEN_W-1:0]    hdr_len;
   logic [WCNT_W-1:0]   hdr_w;
   logic [ADDR_W-1:0]   next_p;
   logic                start;
   logic                hdr_ld;
   logic                issue;
   logic                commit;
   logic                pop;
   logic                space_ok;
   logic [2:0]          occ;
   logic                sk_in_ready;
   logic [1:0]          sk_level;
   logic                push;
   beat_t               push_beat;
   beat_t               out_beat;

   assign avail   = (p_q != cw_q);
   assign hdr_len = rd_data[LEN_LSB +: LEN_W];
   assign hdr_w   = WCNT_W'((17'(hdr_len) + 17'd7) >> 3);
   assign next_p  = p_q + ADDR_W'(w_q) + ADDR_W'(1);
   assign pop     = m_axis_tvalid && m_axis_tready;
   assign push    = infl_q && sk_in_ready;

   // Entries held or in flight after this cycle's pop; one must stay free for a new read.
   assign occ      = 3'(sk_level) + 3'(infl_q) - 3'(pop);
   assign space_ok = (occ <= 3'd1);

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (avail) state_d = HDR;
         HDR:     state_d = (hdr_w != '0) ? DATA : COMMIT;
         DATA:    if (pop && m_axis_tlast) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      start  = 1'b0;
      hdr_ld = 1'b0;
      issue  = 1'b0;
      commit = 1'b0;
      unique case (state_q)
         IDLE:    start  = avail;
         HDR:     hdr_ld = 1'b1;
         DATA:    issue  = (iss_cnt_q != w_q) && space_ok;
         COMMIT:  commit = 1'b1;
         default: ;
      endcase
   end

   // rd_addr always shows the next address; a read is consumed when issue is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q       <= '0;
         cw_q      <= '0;
         rd_ptr_q  <= '0;
         crd_q     <= '0;
         upd_q     <= 1'b0;
         hdr_q     <= '0;
         w_q       <= '0;
         iss_cnt_q <= '0;
         psh_cnt_q <= '0;
         infl_q    <= 1'b0;
      end else begin
         cw_q   <= commited_wr_address;
         upd_q  <= commit;
         infl_q <= issue;
         if (start) rd_ptr_q <= p_q + ADDR_W'(1);
         if (hdr_ld) begin
            hdr_q     <= {rd_data[DES_LSB +: 8], rd_data[SRC_LSB +: 8], hdr_len};
            w_q       <= hdr_w;
            iss_cnt_q <= '0;
            psh_cnt_q <= '0;
         end
         if (issue) begin
            rd_ptr_q  <= rd_ptr_q + ADDR_W'(1);
            iss_cnt_q <= iss_cnt_q + WCNT_W'(1);
         end
         if (push) psh_cnt_q <= psh_cnt_q + WCNT_W'(1);
         if (commit) begin
            p_q      <= next_p;
            crd_q    <= next_p;
            rd_ptr_q <= next_p;
         end
      end
   end

   always_comb begin
      push_beat.data = rd_data;
      push_beat.user = hdr_q;
      push_beat.last = (psh_cnt_q == w_q - WCNT_W'(1));
      push_beat.strb = push_beat.last ? strb_from_len(hdr_q[LEN_W-1:0]) : 8'hFF;
   end

   rx_skid_buf u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (infl_q),
      .in_ready  (sk_in_ready),
      .in_beat   (push_beat),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_beat  (out_beat),
      .level     (sk_level)
   );

   assign m_axis_tdata        = out_beat.data;
   assign m_axis_tstrb        = out_beat.strb;
   assign m_axis_tuser        = out_beat.user;
   assign m_axis_tlast        = out_beat.last;
   assign rd_addr             = rd_ptr_q;
   assign commited_rd_address = crd_q;
   assign rd_addr_updated     = upd_q;

`ifdef RX_BUF_READER_STATS_EN
   // Frame and byte totals, updated once per committed frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_frames <= '0;
         rx_bytes  <= '0;
      end else if (commit) begin
         rx_frames <= rx_frames + 32'd1;
         rx_bytes  <= rx_bytes + 48'(hdr_q[LEN_W-1:0]);
      end
   end
`endif

endmodule

// File: tb/tb_rx_buf_reader.sv
// Directed bench for rx_buf_reader: buffer model, AXI-Stream monitor and frame checks.
module tb_rx_buf_reader;

   localparam int unsigned ADDR_W = 12;
   localparam int DEPTH = 1 << ADDR_W;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  strb;
      logic [31:0] user;
      logic        last;
      int          cyc;
   } beat_rec_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] commited_wr_address = '0;
   logic [ADDR_W-1:0] rd_addr;
   logic [63:0]       rd_data = '0;
   logic [63:0]       m_axis_tdata;
   logic [7:0]        m_axis_tstrb;
   logic [31:0]       m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready = 1'b1;
   logic [ADDR_W-1:0] commited_rd_address;
   logic              rd_addr_updated;
`ifdef RX_BUF_READER_STATS_EN
   logic [31:0]       rx_frames;
   logic [47:0]       rx_bytes;
`endif

   logic [63:0]       mem [DEPTH];
   beat_rec_t         beat_q [$];
   int                cyc = 0;
   int                n_vec = 0;
   int                n_err = 0;
   int                upd_cnt = 0;
   int                stall_err = 0;
   logic [ADDR_W-1:0] last_commit = '0;
   bit                tready_toggle = 1'b0;
   bit                held_v = 1'b0;
   logic [104:0]      held = '0;

   rx_buf_reader #(.ADDR_W(ADDR_W)) dut (
      .clk                 (clk),
      .reset               (reset),
      .commited_wr_address (commited_wr_address),
      .rd_addr             (rd_addr),
      .rd_data             (rd_data),
      .m_axis_tdata        (m_axis_tdata),
      .m_axis_tstrb        (m_axis_tstrb),
      .m_axis_tuser        (m_axis_tuser),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tlast        (m_axis_tlast),
      .m_axis_tready       (m_axis_tready),
      .commited_rd_address (commited_rd_address),
      .rd_addr_updated     (rd_addr_updated)
`ifdef RX_BUF_READER_STATS_EN
      ,
      .rx_frames           (rx_frames),
      .rx_bytes            (rx_bytes)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous buffer RAM: data appears one cycle after the address.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_data <= mem[rd_addr];
   end

   // Drives tready for the coming edge, records accepted beats and stall stability.
   always @(negedge clk) begin
      m_axis_tready = tready_toggle ? cyc[0] : 1'b1;
      if (m_axis_tvalid === 1'b1) begin
         if (held_v && held !== {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast})
            stall_err++;
         held_v = !m_axis_tready;
         held   = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
         if (m_axis_tready)
            beat_q.push_back('{m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast, cyc});
      end else begin
         if (held_v) stall_err++;
         held_v = 1'b0;
      end
      if (rd_addr_updated === 1'b1) begin
         upd_cnt++;
         last_commit = commited_rd_address;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] data_word(input int a);
      return {32'hC0DE_0000 | 32'(a), ~32'(a)};
   endfunction

   function automatic int words_of(input logic [15:0] len);
      return (int'(len) + 7) >> 3;
   endfunction

   task automatic start_frame(input int hdr, input logic [7:0] des, input logic [7:0] src,
                              input logic [15:0] len, input bit toggle, output int start_cyc);
      int w;
      w = words_of(len);
      mem[hdr] = {des, src, len, 32'h0BAD_F00D};
      for (int i = 0; i < w; i++) mem[(hdr + 1 + i) % DEPTH] = data_word((hdr + 1 + i) % DEPTH);
      @(negedge clk);
      beat_q.delete();
      upd_cnt       = 0;
      stall_err     = 0;
      tready_toggle = toggle;
      start_cyc     = cyc;
      commited_wr_address = ADDR_W'((hdr + 1 + w) % DEPTH);
   endtask

   task automatic finish_frame(input string tag, input int hdr, input logic [7:0] des,
                               input logic [7:0] src, input logic [15:0] len,
                               input int start_cyc, input bit chk_lat, input bit chk_rate);
      int w;
      int a;
      int guard;
      int exp_commit;
      logic [7:0]  exp_strb;
      logic [31:0] exp_user;
      w          = words_of(len);
      exp_commit = (hdr + 1 + w) % DEPTH;
      exp_user   = {des, src, len};
      guard      = 0;
      while (upd_cnt == 0 && guard < w + 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " commit_seen"}, 64'(upd_cnt != 0), 64'd1);
      repeat (8) @(negedge clk);
      check({tag, " beats"},       64'(beat_q.size()), 64'(w));
      check({tag, " strobes"},     64'(upd_cnt), 64'd1);
      check({tag, " commit_addr"}, 64'(last_commit), 64'(exp_commit));
      check({tag, " rd_ptr_out"},  64'(commited_rd_address), 64'(exp_commit));
      check({tag, " stable"},      64'(stall_err), 64'd0);
      for (int i = 0; i < beat_q.size() && i < w; i++) begin
         a = (hdr + 1 + i) % DEPTH;
         exp_strb = (i == w - 1 && len[2:0] != 3'd0) ? 8'((9'd1 << len[2:0]) - 9'd1) : 8'hFF;
         check($sformatf("%s b%0d data", tag, i), beat_q[i].data, data_word(a));
         check($sformatf("%s b%0d strb", tag, i), 64'(beat_q[i].strb), 64'(exp_strb));
         check($sformatf("%s b%0d user", tag, i), 64'(beat_q[i].user), 64'(exp_user));
         check($sformatf("%s b%0d last", tag, i), 64'(beat_q[i].last), 64'(i == w - 1));
      end
      if (chk_lat && beat_q.size() > 0)
         check({tag, " latency_ok"}, 64'(beat_q[0].cyc - start_cyc <= 5), 64'd1);
      if (chk_rate && w > 0 && beat_q.size() == w)
         check({tag, " rate"}, 64'(beat_q[w-1].cyc - beat_q[0].cyc), 64'(w - 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, " tlast"},  64'(m_axis_tlast), 64'd0);
      check({tag, " tdata"},  m_axis_tdata, 64'd0);
      check({tag, " tstrb"},  64'(m_axis_tstrb), 64'd0);
      check({tag, " tuser"},  64'(m_axis_tuser), 64'd0);
      check({tag, " crd"},    64'(commited_rd_address), 64'd0);
      check({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
      check({tag, " upd"},    64'(rd_addr_updated), 64'd0);
   endtask

   initial begin
      int sc;
      int guard;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      start_frame(0, 8'h11, 8'h22, 16'd64, 1'b0, sc);
      finish_frame("len64", 0, 8'h11, 8'h22, 16'd64, sc, 1'b1, 1'b1);
      start_frame(9, 8'hA5, 8'h5A, 16'd61, 1'b0, sc);
      finish_frame("len61", 9, 8'hA5, 8'h5A, 16'd61, sc, 1'b1, 1'b1);
      start_frame(18, 8'h03, 8'h04, 16'd0, 1'b0, sc);
      finish_frame("len0", 18, 8'h03, 8'h04, 16'd0, sc, 1'b0, 1'b0);
      start_frame(19, 8'h77, 8'h88, 16'd64, 1'b1, sc);
      finish_frame("stall", 19, 8'h77, 8'h88, 16'd64, sc, 1'b0, 1'b0);

      // Reset in the middle of a frame, then expect a full replay from the header.
      @(negedge clk);
      tready_toggle       = 1'b0;
      reset               = 1'b1;
      commited_wr_address = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      start_frame(0, 8'h3C, 8'hC3, 16'd64, 1'b0, sc);
      guard = 0;
      while (beat_q.size() < 2 && guard < 50) begin
         @(posedge clk);
         guard++;
      end
      check("midreset two_beats_seen", 64'(beat_q.size() >= 2), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      check("midreset no_commit", 64'(upd_cnt), 64'd0);
      reset = 1'b0;
      beat_q.delete();
      upd_cnt = 0;
      sc = cyc;
      finish_frame("replay", 0, 8'h3C, 8'hC3, 16'd64, sc, 1'b0, 1'b1);

      start_frame(9, 8'h01, 8'h02, 16'd32672, 1'b0, sc);
      finish_frame("fill", 9, 8'h01, 8'h02, 16'd32672, sc, 1'b0, 1'b1);
      start_frame(4094, 8'hEE, 8'hDD, 16'd24, 1'b0, sc);
      finish_frame("wrap", 4094, 8'hEE, 8'hDD, 16'd24, sc, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rx_buf_reader.md
RX_BUF_READER -- requirements
Module: rx_buf_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: buffer address width; all addresses wrap modulo 2^ADDR_W.
REQ-002 SHALL have the following ports; there is one clock, and reset is synchronous and active-high:
  clk  in  1  sole clock
  reset  in  1  synchronous, active-high
  commited_wr_address  in  ADDR_W  writer commit pointer; points at the next free header slot
  rd_addr  out  ADDR_W  buffer read address
  rd_data  in  64  buffer read data, valid 1 cycle after rd_addr
  m_axis_tdata  out  64  frame data
  m_axis_tstrb  out  8  byte enables
  m_axis_tuser  out  32  {des_port, src_port, byte_len}; valid on the first beat
  m_axis_tvalid  out  1  beat valid
  m_axis_tlast  out  1  last beat of frame
  m_axis_tready  in  1  consumer ready
  commited_rd_address  out  ADDR_W  reader commit pointer
  rd_addr_updated  out  1  one-cycle strobe after commited_rd_address changes

Function
REQ-003 SHALL read each frame as a header word at the reader pointer P, followed by data words at P+1 .. P+W; header fields are des=[63:56], src=[55:48], len=[47:32].
REQ-004 SHALL compute W = (len+7)>>3 in 14 bits; len=0 means W=0 and no data beats are produced.
REQ-005 SHALL register commited_wr_address once (cw_q) and treat a frame as available only when P != cw_q.
REQ-006 SHALL implement the states IDLE, HDR, DATA and COMMIT.
REQ-007 IDLE SHALL drive rd_addr=P and move to HDR when a frame is available.
REQ-008 HDR SHALL latch the header from rd_data; it then goes to DATA if W>0, else to COMMIT.
REQ-009 DATA SHALL issue reads P+1..P+W in order.
REQ-010 DATA SHALL issue a read only when the output skid buffer is guaranteed space for it.
REQ-011 DATA SHALL go to COMMIT once all W beats have been accepted (tvalid&&tready).
REQ-012 COMMIT SHALL set P = P+1+W and commited_rd_address = P+1+W, then return to IDLE.
REQ-013 rd_addr_updated SHALL be 1 for exactly the single cycle following a commited_rd_address update.
REQ-014 SHALL not commit back-to-back: at least 2 cycles SHALL separate two updates.
REQ-015 m_axis_tuser SHALL carry the latched header on every beat of the frame.
REQ-016 m_axis_tlast SHALL be 1 only on beat W.
REQ-017 tstrb SHALL be 8'hFF on every beat except the last.
REQ-018 On the last beat, tstrb SHALL be 8'hFF when len[2:0]=0; otherwise the low len[2:0] bits SHALL be set.
REQ-019 Once tvalid is asserted, tdata, tstrb, tuser and tlast SHALL hold stable until the beat is accepted (AXI-Stream rule).
REQ-020 With tready held high, throughput SHALL be one beat per cycle.
REQ-021 First-beat latency SHALL be at most 4 cycles after cw_q differs from P.
REQ-022 Address increments SHALL wrap from 2^ADDR_W-1 to 0 without a gap.
REQ-023 If commited_wr_address changes during a frame, the block SHALL not affect that frame.
REQ-024 The block SHALL never read past cw_q.

Reset
REQ-025 Reset SHALL set P=0, commited_rd_address=0, rd_addr=0 and rd_addr_updated=0.
REQ-026 Reset SHALL set m_axis_tvalid=0, m_axis_tlast=0, tdata=0, tstrb=0 and tuser=0.
REQ-027 Reset SHALL empty the skid buffer and set the state to IDLE.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no commit.

Configuration
REQ-029 The macro RX_BUF_READER_STATS_EN SHALL control the statistics feature.
REQ-030 When RX_BUF_READER_STATS_EN is defined, the block SHALL add outputs rx_frames (32 bits) and rx_bytes (48 bits).
REQ-031 rx_frames SHALL increment by 1, and rx_bytes by len, in each COMMIT cycle.
REQ-032 Both counters SHALL wrap and SHALL clear on reset.
REQ-033 When RX_BUF_READER_STATS_EN is not defined, these ports and their logic SHALL be absent.

Structure
REQ-034 A shared package SHALL hold the state encoding, the header field offsets (DES_LSB=56, SRC_LSB=48, LEN_LSB=32) and the strobe-from-len function.
REQ-035 The skid buffer SHALL be a sub-module rx_skid_buf: 2 entries of 64+8+32+1 bits, with valid/ready on both sides.

Verification
REQ-036 Single frame, len=64, header at 0, cw 0->9, tready=1 -> 8 beats; tlast on beat 8; last tstrb=FF; commited_rd_address=9; rd_addr_updated pulses once.
REQ-037 Single frame, len=61 -> 8 beats; last tstrb=8'h1F; tuser={des,src,16'd61} on all beats.
REQ-038 Single frame, len=0 -> no beats; commit P+1; one strobe.
REQ-039 Frame with header at 2^ADDR_W-2 and len=24 -> reads at addresses 4094, 4095, 0, 1; commit=2.
REQ-040 Frame of len=64 with tready toggling 1010... -> 8 beats in order; data stable while stalled; no beat lost or duplicated.
REQ-041 Reset asserted on beat 3 of 8 -> all outputs at reset values next cycle; commited_rd_address=0; after release, the same frame is replayed from its header.
